// File: rtl/matmul_sp_reader.sv
// APB initiator that reads a result matrix out of a matmul scratchpad into a flat image.
// Optional FLAGS register snapshot before the element reads: MATMUL_READBACK_FLAGS_EN.
module matmul_sp_reader #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BUS_WIDTH   = 16,
  parameter int unsigned MAX_DIM     = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned SP_NTARGETS = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic [$clog2(SP_NTARGETS)-1:0]       sp_sel_i,
  input  logic [$clog2(MAX_DIM):0]             rows_i,
  input  logic [$clog2(MAX_DIM):0]             cols_i,
  output logic [ADDR_WIDTH-1:0]                paddr_o,
  output logic                                 psel_o,
  output logic                                 penable_o,
  output logic                                 pwrite_o,
  output logic [DATA_WIDTH-1:0]                pwdata_o,
  output logic [DATA_WIDTH/8-1:0]              pstrb_o,
  input  logic [DATA_WIDTH-1:0]                prdata_i,
  input  logic                                 pready_i,
  input  logic                                 pslverr_i,
  output logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] data_sp_o,
  output logic [DATA_WIDTH-1:0]                flags_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o
);

  localparam int unsigned SelW   = $clog2(SP_NTARGETS);
  localparam int unsigned DimW   = $clog2(MAX_DIM) + 1;
  localparam int unsigned IdxW   = $clog2(MAX_DIM * MAX_DIM);
  localparam int unsigned IdxLsb = 5 + SelW;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e                               state_q;
  logic [SelW-1:0]                      sel_q;
  logic [DimW-1:0]                      rows_q, cols_q, i_q, j_q;
  logic [ADDR_WIDTH-1:0]                paddr_q;
  logic                                 psel_q, penable_q, busy_q, done_q, err_q;
  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] data_q;

  logic            last_col, last_elem;
  logic [DimW-1:0] i_next, j_next;

  function automatic logic [DimW-1:0] clamp_dim(input logic [DimW-1:0] v);
    return (v > DimW'(MAX_DIM)) ? DimW'(MAX_DIM) : v;
  endfunction

  function automatic logic [IdxW-1:0] elem_idx(input logic [DimW-1:0] i, input logic [DimW-1:0] j);
    return IdxW'(i) * IdxW'(MAX_DIM) + IdxW'(j);
  endfunction

  // Layout: [4:0] SP region code, then SP select, then row-major element index.
  function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [SelW-1:0] sel,
                                                      input logic [IdxW-1:0] idx);
    logic [ADDR_WIDTH-1:0] a;
    a = ADDR_WIDTH'(idx) << IdxLsb;
    a[IdxLsb-1:5] = sel;
    a[4:0] = 5'b10000;
    return a;
  endfunction

  assign last_col  = (j_q == cols_q - 1'b1);
  assign last_elem = last_col && (i_q == rows_q - 1'b1);
  assign j_next    = last_col ? '0 : j_q + 1'b1;
  assign i_next    = last_col ? i_q + 1'b1 : i_q;

`ifdef MATMUL_READBACK_FLAGS_EN
  localparam logic [ADDR_WIDTH-1:0] FlagsAddr = ADDR_WIDTH'(5'b01100);
  logic                  flags_phase_q;
  logic [DATA_WIDTH-1:0] flags_q;
  assign flags_o = flags_q;
`else
  logic unused_prdata;
  assign unused_prdata = ^prdata_i;
  assign flags_o = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      i_q       <= '0;
      j_q       <= '0;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
`ifdef MATMUL_READBACK_FLAGS_EN
      flags_phase_q <= 1'b0;
      flags_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            sel_q  <= sp_sel_i;
            rows_q <= clamp_dim(rows_i);
            cols_q <= clamp_dim(cols_i);
            i_q    <= '0;
            j_q    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
`ifdef MATMUL_READBACK_FLAGS_EN
            flags_phase_q <= 1'b1;
            paddr_q       <= FlagsAddr;
            psel_q        <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= StSetup;
`else
            if (rows_i == '0 || cols_i == '0) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              paddr_q <= elem_addr(sp_sel_i, '0);
              psel_q  <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= StSetup;
            end
`endif
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          state_q   <= StAccess;
        end
        StAccess: begin
          if (pready_i) begin
            penable_q <= 1'b0;
            if (pslverr_i) begin
              err_q   <= 1'b1;
              psel_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
`ifdef MATMUL_READBACK_FLAGS_EN
            else if (flags_phase_q) begin
              flags_q       <= prdata_i;
              flags_phase_q <= 1'b0;
              if (rows_q == '0 || cols_q == '0) begin
                psel_q  <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= StDone;
              end else begin
                paddr_q <= elem_addr(sel_q, '0);
                state_q <= StSetup;
              end
            end
`endif
            else begin
              data_q[BUS_WIDTH*elem_idx(i_q, j_q) +: BUS_WIDTH] <= prdata_i[BUS_WIDTH-1:0];
              if (last_elem) begin
                psel_q  <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= StDone;
              end else begin
                i_q     <= i_next;
                j_q     <= j_next;
                paddr_q <= elem_addr(sel_q, elem_idx(i_next, j_next));
                state_q <= StSetup;
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign paddr_o   = paddr_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = 1'b0;
  assign pwdata_o  = '0;
  assign pstrb_o   = '0;
  assign data_sp_o = data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_matmul_sp_reader.sv
// Directed bench for matmul_sp_reader: APB slave model plus scoreboard of expected addresses.
module tb_matmul_sp_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   sp_sel;
  logic [2:0]   rows, cols;
  logic [31:0]  paddr;
  logic         psel, penable, pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata = '0;
  logic         pready = 1'b0;
  logic         pslverr = 1'b0;
  logic [255:0] data_sp;
  logic [31:0]  flags;
  logic         busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [16];
  logic [31:0] flags_val = 32'h5;
  int          wait_states = 0;
  int          err_idx = -1;
  int          wcnt = 0;
  int          sidx;
  int          psel_cnt = 0;
  logic [31:0] addr_q[$];
  logic [15:0] exp_e [16];
  bit          exp_err;
  bit          reached;

  matmul_sp_reader dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .sp_sel_i  (sp_sel),
    .rows_i    (rows),
    .cols_i    (cols),
    .paddr_o   (paddr),
    .psel_o    (psel),
    .penable_o (penable),
    .pwrite_o  (pwrite),
    .pwdata_o  (pwdata),
    .pstrb_o   (pstrb),
    .prdata_i  (prdata),
    .pready_i  (pready),
    .pslverr_i (pslverr),
    .data_sp_o (data_sp),
    .flags_o   (flags),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: responds after wait_states cycles in ACCESS; data from mem by element index.
  always @(posedge clk) begin
    #2;
    if (psel && penable) begin
      if (wcnt >= wait_states) begin
        pready = 1'b1;
        if (paddr[4:0] == 5'h0C) begin
          prdata  = flags_val;
          pslverr = 1'b0;
        end else begin
          sidx    = int'(paddr >> 7);
          prdata  = mem[sidx[3:0]];
          pslverr = (sidx == err_idx);
        end
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
      end
      wcnt++;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      wcnt    = 0;
    end
  end

  always @(negedge clk) begin
    if (psel) psel_cnt++;
    if (rst_n && psel && penable && pready) begin
      if (addr_q.size() == 0) check("paddr_extra_access", 64'(addr_q.size()), 64'd1);
      else check("paddr", paddr, addr_q.pop_front());
    end
  end

  // Builds the expected address sequence and the expected element image.
  task automatic push_seq(input int sel, input int r_in, input int c_in, input int eidx);
    int r, c;
    bit stop;
    r = (r_in > 4) ? 4 : r_in;
    c = (c_in > 4) ? 4 : c_in;
    stop = 1'b0;
    for (int k = 0; k < 16; k++) exp_e[k] = '0;
`ifdef MATMUL_READBACK_FLAGS_EN
    addr_q.push_back(32'h0C);
`endif
    for (int i = 0; i < r; i++) begin
      for (int j = 0; j < c; j++) begin
        if (!stop) begin
          addr_q.push_back(32'h10 | (32'(sel) << 5) | (32'(i * 4 + j) << 7));
          if (i * 4 + j == eidx) stop = 1'b1;
          else exp_e[i * 4 + j] = mem[i * 4 + j][15:0];
        end
      end
    end
    exp_err = stop;
  endtask

  task automatic run(input string name, input int sel, input int r, input int c,
                     input int waits, input int eidx, input int lat_exp);
    int lat;
    int lat_req;
    lat_req = lat_exp;
`ifdef MATMUL_READBACK_FLAGS_EN
    lat_req += 2 + waits;
`endif
    wait_states = waits;
    err_idx     = eidx;
    push_seq(sel, r, c, eidx);
    psel_cnt = 0;
    @(negedge clk);
    start  = 1'b1;
    sp_sel = 2'(sel);
    rows   = 3'(r);
    cols   = 3'(c);
    @(posedge clk);
    #1;
    start  = 1'b0;
    sp_sel = ~sp_sel;
    rows   = 3'd1;
    cols   = 3'd3;
    lat = 1;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(lat_req));
    check({name, "_err"}, 64'(err), 64'(exp_err));
    check({name, "_busy_at_done"}, 64'(busy), 64'd0);
    check({name, "_addr_q_drained"}, 64'(addr_q.size()), 64'd0);
    for (int k = 0; k < 16; k++)
      check($sformatf("%s_elem%0d", name, k), 64'(data_sp[k*16 +: 16]), 64'(exp_e[k]));
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, 64'(done), 64'd0);
    check({name, "_hold_elem0"}, 64'(data_sp[15:0]), 64'(exp_e[0]));
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    sp_sel = '0;
    rows   = '0;
    cols   = '0;
    for (int k = 0; k < 16; k++) mem[k] = 32'(10 * (k / 4) + (k % 4));
    repeat (3) @(posedge clk);
    #1;
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_data", 64'(|data_sp), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("tied_apb", {pwrite, pstrb, pwdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2x2 from SP1, 10*i+j data, no wait states.
    run("t1", 1, 2, 2, 0, -1, 9);

    // 4x4, 3 wait states, element (3,3) returns 0xFFF0 in its low half.
    for (int k = 0; k < 16; k++) mem[k] = 32'(k * 3 + 1) | 32'hABCD_0000;
    mem[15] = 32'h1234_FFF0;
    run("t2", 2, 4, 4, 3, -1, 81);
    check("t2_elem33_signed", 64'($signed(data_sp[255:240])), 64'($signed(-16)));

    // 3x2 with slave error on element (1,0).
    run("t3", 0, 3, 2, 0, 4, 7);

    // Zero rows: no element accesses, error cleared.
    psel_cnt = 0;
    run("t4", 3, 0, 3, 0, -1, 1);
`ifdef MATMUL_READBACK_FLAGS_EN
    check("t4_psel_cycles", 64'(psel_cnt), 64'd2);
`else
    check("t4_psel_cycles", 64'(psel_cnt), 64'd0);
`endif

    // Oversized dimension clamps to MAX_DIM.
    run("t5", 3, 7, 1, 0, -1, 9);

`ifdef MATMUL_READBACK_FLAGS_EN
    flags_val = 32'h5;
    run("t6", 0, 1, 1, 0, -1, 3);
    check("t6_flags", 64'(flags), 64'h5);
`else
    check("flags_tied", 64'(flags), 64'd0);
`endif

    // Mid-transfer start is ignored; async reset during ACCESS.
    for (int k = 0; k < 16; k++) mem[k] = 32'(100 + k);
    wait_states = 2;
    err_idx = -1;
    push_seq(1, 2, 2, -1);
    @(negedge clk);
    start  = 1'b1;
    sp_sel = 2'd1;
    rows   = 3'd2;
    cols   = 3'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start  = 1'b1;
    sp_sel = 2'd3;
    rows   = 3'd1;
    cols   = 3'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 60 && !reached; k++) begin
      @(negedge clk);
      #1;
      if (addr_q.size() == 2 && penable && !pready) reached = 1'b1;
    end
    check("rst_mid_reached_access", 64'(reached), 64'd1);
    check("rst_mid_busy", 64'(busy), 64'd1);
    check("rst_mid_elem1", 64'(data_sp[31:16]), 64'(mem[1][15:0]));
    rst_n = 1'b0;
    #1;
    check("rst_mid_psel", 64'(psel), 64'd0);
    check("rst_mid_penable", 64'(penable), 64'd0);
    check("rst_mid_data", 64'(|data_sp), 64'd0);
    check("rst_mid_busy_clr", 64'(busy), 64'd0);
    addr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery from IDLE after reset.
    run("t7", 2, 1, 2, 0, -1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
